// File: rtl/reservation_station_pkg.sv
// Shared widths and ALU operation encodings for the reservation station.
package reservation_station_pkg;

  localparam int ROB_SIZE_BIT = 4;
  localparam int RS_TYPE_BIT  = 5;
  localparam int RS_SIZE_BIT  = 2;

  typedef enum logic [RS_TYPE_BIT-1:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_SLL  = 5'd5,
    OP_SRL  = 5'd6,
    OP_SRA  = 5'd7,
    OP_SLT  = 5'd8,
    OP_SLTU = 5'd9
  } alu_op_e;

endpackage

// File: rtl/reservation_station_lowest_one_picker.sv
// Finds the index of the lowest set bit of a request vector.
module lowest_one_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit wins
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds dispatched ops until operands are ready,
// snoops the ALU and load-store broadcasts, and issues one op per cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE  = 4,
  parameter int ROB_BITS = ROB_SIZE_BIT
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear_in,
  input  logic                   dispatch_valid,
  input  logic [RS_TYPE_BIT-1:0] dispatch_op_type,
  input  logic [31:0]            dispatch_vj,
  input  logic [31:0]            dispatch_vk,
  input  logic                   dispatch_qj_busy,
  input  logic                   dispatch_qk_busy,
  input  logic [ROB_BITS-1:0]    dispatch_qj,
  input  logic [ROB_BITS-1:0]    dispatch_qk,
  input  logic [ROB_BITS-1:0]    dispatch_rob_idx,
  output logic                   full,
  input  logic                   alu_cdb_ready,
  input  logic [31:0]            alu_cdb_result,
  input  logic [ROB_BITS-1:0]    alu_cdb_rob_idx,
  input  logic                   lsb_cdb_ready,
  input  logic [31:0]            lsb_cdb_result,
  input  logic [ROB_BITS-1:0]    lsb_cdb_rob_idx,
  output logic                   alu_valid,
  output logic [31:0]            alu_r1,
  output logic [31:0]            alu_r2,
  output logic [ROB_BITS-1:0]    alu_rob_idx,
  output logic [RS_TYPE_BIT-1:0] alu_op_type
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]     busy;
  logic [RS_SIZE-1:0]     qj_busy;
  logic [RS_SIZE-1:0]     qk_busy;
  logic [RS_TYPE_BIT-1:0] op      [RS_SIZE];
  logic [ROB_BITS-1:0]    rob_idx [RS_SIZE];
  logic [31:0]            vj      [RS_SIZE];
  logic [31:0]            vk      [RS_SIZE];
  logic [ROB_BITS-1:0]    qj      [RS_SIZE];
  logic [ROB_BITS-1:0]    qk      [RS_SIZE];

  logic [RS_SIZE-1:0] ready_vec;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   issue_idx;
  logic               free_any;
  logic               issue_any;
  logic               dispatch_accept;

  logic        disp_qj_busy;
  logic        disp_qk_busy;
  logic [31:0] disp_vj;
  logic [31:0] disp_vk;

  assign full            = &busy;
  assign dispatch_accept = dispatch_valid & free_any;

  // An entry can issue once it holds an op and neither operand is pending
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy[i] & ~qj_busy[i] & ~qk_busy[i];
    end
  end

  lowest_one_picker #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_pick (
    .req (~busy),
    .idx (free_idx),
    .any (free_any)
  );

  lowest_one_picker #(.N(RS_SIZE), .IDX_W(IDX_W)) u_issue_pick (
    .req (ready_vec),
    .idx (issue_idx),
    .any (issue_any)
  );

  // Capture a same-cycle broadcast for the incoming op so it is not missed
  always_comb begin
    disp_qj_busy = dispatch_qj_busy;
    disp_qk_busy = dispatch_qk_busy;
    disp_vj      = dispatch_vj;
    disp_vk      = dispatch_vk;
    if (dispatch_qj_busy) begin
      if (alu_cdb_ready && alu_cdb_rob_idx == dispatch_qj) begin
        disp_qj_busy = 1'b0;
        disp_vj      = alu_cdb_result;
      end else if (lsb_cdb_ready && lsb_cdb_rob_idx == dispatch_qj) begin
        disp_qj_busy = 1'b0;
        disp_vj      = lsb_cdb_result;
      end
    end
    if (dispatch_qk_busy) begin
      if (alu_cdb_ready && alu_cdb_rob_idx == dispatch_qk) begin
        disp_qk_busy = 1'b0;
        disp_vk      = alu_cdb_result;
      end else if (lsb_cdb_ready && lsb_cdb_rob_idx == dispatch_qk) begin
        disp_qk_busy = 1'b0;
        disp_vk      = lsb_cdb_result;
      end
    end
  end

  // Entry storage, wakeup, dispatch and registered issue to the ALU
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy        <= '0;
      qj_busy     <= '0;
      qk_busy     <= '0;
      alu_valid   <= 1'b0;
      alu_r1      <= '0;
      alu_r2      <= '0;
      alu_rob_idx <= '0;
      alu_op_type <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        busy      <= '0;
        alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && qj_busy[i]) begin
            if (alu_cdb_ready && alu_cdb_rob_idx == qj[i]) begin
              vj[i]      <= alu_cdb_result;
              qj_busy[i] <= 1'b0;
            end else if (lsb_cdb_ready && lsb_cdb_rob_idx == qj[i]) begin
              vj[i]      <= lsb_cdb_result;
              qj_busy[i] <= 1'b0;
            end
          end
          if (busy[i] && qk_busy[i]) begin
            if (alu_cdb_ready && alu_cdb_rob_idx == qk[i]) begin
              vk[i]      <= alu_cdb_result;
              qk_busy[i] <= 1'b0;
            end else if (lsb_cdb_ready && lsb_cdb_rob_idx == qk[i]) begin
              vk[i]      <= lsb_cdb_result;
              qk_busy[i] <= 1'b0;
            end
          end
        end

        if (issue_any) begin
          alu_valid       <= 1'b1;
          alu_r1          <= vj[issue_idx];
          alu_r2          <= vk[issue_idx];
          alu_rob_idx     <= rob_idx[issue_idx];
          alu_op_type     <= op[issue_idx];
          busy[issue_idx] <= 1'b0;
        end else begin
          alu_valid <= 1'b0;
        end

        if (dispatch_accept) begin
          busy[free_idx]    <= 1'b1;
          op[free_idx]      <= dispatch_op_type;
          rob_idx[free_idx] <= dispatch_rob_idx;
          vj[free_idx]      <= disp_vj;
          vk[free_idx]      <= disp_vk;
          qj_busy[free_idx] <= disp_qj_busy;
          qk_busy[free_idx] <= disp_qk_busy;
          qj[free_idx]      <= dispatch_qj;
          qk[free_idx]      <= dispatch_qk;
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for the reservation station.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int RB = ROB_SIZE_BIT;

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic                   rdy_in;
  logic                   clear_in;
  logic                   dispatch_valid;
  logic [RS_TYPE_BIT-1:0] dispatch_op_type;
  logic [31:0]            dispatch_vj;
  logic [31:0]            dispatch_vk;
  logic                   dispatch_qj_busy;
  logic                   dispatch_qk_busy;
  logic [RB-1:0]          dispatch_qj;
  logic [RB-1:0]          dispatch_qk;
  logic [RB-1:0]          dispatch_rob_idx;
  logic                   full;
  logic                   alu_cdb_ready;
  logic [31:0]            alu_cdb_result;
  logic [RB-1:0]          alu_cdb_rob_idx;
  logic                   lsb_cdb_ready;
  logic [31:0]            lsb_cdb_result;
  logic [RB-1:0]          lsb_cdb_rob_idx;
  logic                   alu_valid;
  logic [31:0]            alu_r1;
  logic [31:0]            alu_r2;
  logic [RB-1:0]          alu_rob_idx;
  logic [RS_TYPE_BIT-1:0] alu_op_type;

  int passed = 0;
  int total  = 0;

  reservation_station #(.RS_SIZE(4), .ROB_BITS(RB)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .clear_in         (clear_in),
    .dispatch_valid   (dispatch_valid),
    .dispatch_op_type (dispatch_op_type),
    .dispatch_vj      (dispatch_vj),
    .dispatch_vk      (dispatch_vk),
    .dispatch_qj_busy (dispatch_qj_busy),
    .dispatch_qk_busy (dispatch_qk_busy),
    .dispatch_qj      (dispatch_qj),
    .dispatch_qk      (dispatch_qk),
    .dispatch_rob_idx (dispatch_rob_idx),
    .full             (full),
    .alu_cdb_ready    (alu_cdb_ready),
    .alu_cdb_result   (alu_cdb_result),
    .alu_cdb_rob_idx  (alu_cdb_rob_idx),
    .lsb_cdb_ready    (lsb_cdb_ready),
    .lsb_cdb_result   (lsb_cdb_result),
    .lsb_cdb_rob_idx  (lsb_cdb_rob_idx),
    .alu_valid        (alu_valid),
    .alu_r1           (alu_r1),
    .alu_r2           (alu_r2),
    .alu_rob_idx      (alu_rob_idx),
    .alu_op_type      (alu_op_type)
  );

  // Free-running clock, period 10
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    dispatch_valid   = 1'b0;
    dispatch_op_type = '0;
    dispatch_vj      = '0;
    dispatch_vk      = '0;
    dispatch_qj_busy = 1'b0;
    dispatch_qk_busy = 1'b0;
    dispatch_qj      = '0;
    dispatch_qk      = '0;
    dispatch_rob_idx = '0;
    alu_cdb_ready    = 1'b0;
    alu_cdb_result   = '0;
    alu_cdb_rob_idx  = '0;
    lsb_cdb_ready    = 1'b0;
    lsb_cdb_result   = '0;
    lsb_cdb_rob_idx  = '0;
  endtask

  task automatic dispatch(input logic [4:0] opc, input logic [31:0] vj, input logic [31:0] vk,
                          input logic qjb, input logic [RB-1:0] qj,
                          input logic qkb, input logic [RB-1:0] qk, input logic [RB-1:0] rob);
    dispatch_valid   = 1'b1;
    dispatch_op_type = opc;
    dispatch_vj      = vj;
    dispatch_vk      = vk;
    dispatch_qj_busy = qjb;
    dispatch_qj      = qj;
    dispatch_qk_busy = qkb;
    dispatch_qk      = qk;
    dispatch_rob_idx = rob;
  endtask

  initial begin
    idle_inputs();
    rst_in   = 1'b0;
    rdy_in   = 1'b1;
    clear_in = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(alu_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_r1", alu_r1, 32'd0);
    check("rst_rob", 32'(alu_rob_idx), 32'd0);
    rst_in = 1'b1;
    tick();

    // Ready-operand dispatch issues one edge later
    dispatch(5'd0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    tick();
    idle_inputs();
    check("basic_no_early_issue", 32'(alu_valid), 32'd0);
    tick();
    check("basic_valid", 32'(alu_valid), 32'd1);
    check("basic_r1", alu_r1, 32'd5);
    check("basic_r2", alu_r2, 32'd7);
    check("basic_rob", 32'(alu_rob_idx), 32'd3);
    check("basic_op", 32'(alu_op_type), 32'd0);
    tick();
    check("basic_one_strobe", 32'(alu_valid), 32'd0);

    // Pending qj woken by ALU broadcast two cycles later
    dispatch(5'd1, 32'hDEAD, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
    tick();
    idle_inputs();
    tick();
    check("wake_wait", 32'(alu_valid), 32'd0);
    alu_cdb_ready   = 1'b1;
    alu_cdb_rob_idx = 4'd2;
    alu_cdb_result  = 32'h10;
    tick();
    idle_inputs();
    check("wake_not_same_edge", 32'(alu_valid), 32'd0);
    tick();
    check("wake_valid", 32'(alu_valid), 32'd1);
    check("wake_r1", alu_r1, 32'h10);
    check("wake_r2", alu_r2, 32'd1);
    check("wake_rob", 32'(alu_rob_idx), 32'd5);
    check("wake_op", 32'(alu_op_type), 32'd1);
    tick();

    // Pending qk caught by a same-cycle load-store broadcast
    dispatch(5'd2, 32'd3, 32'hBAD, 1'b0, 4'd0, 1'b1, 4'd4, 4'd6);
    lsb_cdb_ready   = 1'b1;
    lsb_cdb_rob_idx = 4'd4;
    lsb_cdb_result  = 32'hFF;
    tick();
    idle_inputs();
    check("bypass_no_early", 32'(alu_valid), 32'd0);
    tick();
    check("bypass_valid", 32'(alu_valid), 32'd1);
    check("bypass_r1", alu_r1, 32'd3);
    check("bypass_r2", alu_r2, 32'hFF);
    check("bypass_rob", 32'(alu_rob_idx), 32'd6);
    tick();

    // Fill all four entries with dependent ops, fifth is dropped
    for (int i = 0; i < 4; i++) begin
      dispatch(5'd0, 32'd0, 32'(i), 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(i));
      tick();
    end
    idle_inputs();
    check("fill_full", 32'(full), 32'd1);
    dispatch(5'd4, 32'h55, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
    tick();
    idle_inputs();
    check("full_still", 32'(full), 32'd1);
    tick();
    check("full_drop_no_issue", 32'(alu_valid), 32'd0);
    alu_cdb_ready   = 1'b1;
    alu_cdb_rob_idx = 4'd10;
    alu_cdb_result  = 32'h22;
    tick();
    idle_inputs();
    check("full_wake_full", 32'(full), 32'd1);
    tick();
    check("full_issue_valid", 32'(alu_valid), 32'd1);
    check("full_issue_r1", alu_r1, 32'h22);
    check("full_issue_r2", alu_r2, 32'd2);
    check("full_issue_rob", 32'(alu_rob_idx), 32'd2);
    check("full_drops", 32'(full), 32'd0);
    tick();
    check("full_no_more_issue", 32'(alu_valid), 32'd0);

    // Refill to full, then flush while dispatch and wakeup are also active
    dispatch(5'd0, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'd4);
    tick();
    idle_inputs();
    check("clear_pre_full", 32'(full), 32'd1);
    clear_in = 1'b1;
    alu_cdb_ready   = 1'b1;
    alu_cdb_rob_idx = 4'd8;
    alu_cdb_result  = 32'h77;
    tick();
    clear_in = 1'b0;
    idle_inputs();
    check("clear_full", 32'(full), 32'd0);
    check("clear_valid", 32'(alu_valid), 32'd0);
    alu_cdb_ready   = 1'b1;
    alu_cdb_rob_idx = 4'd9;
    alu_cdb_result  = 32'h88;
    tick();
    idle_inputs();
    tick();
    check("clear_no_issue1", 32'(alu_valid), 32'd0);
    tick();
    check("clear_no_issue2", 32'(alu_valid), 32'd0);

    // Freeze with rdy_in low while a ready entry waits
    dispatch(5'd3, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
    tick();
    rdy_in = 1'b0;
    dispatch(5'd4, 32'h99, 32'h98, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_valid", 32'(alu_valid), 32'd0);
      check("freeze_r1", alu_r1, 32'h22);
    end
    idle_inputs();
    rdy_in = 1'b1;
    tick();
    check("thaw_valid", 32'(alu_valid), 32'd1);
    check("thaw_r1", alu_r1, 32'h11);
    check("thaw_r2", alu_r2, 32'h22);
    check("thaw_rob", 32'(alu_rob_idx), 32'd7);
    check("thaw_op", 32'(alu_op_type), 32'd3);
    tick();
    check("thaw_ignored_dispatch", 32'(alu_valid), 32'd0);

    // Reset mid-operation, with rdy_in low, discards a ready entry
    dispatch(5'd0, 32'h44, 32'h45, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    tick();
    idle_inputs();
    rst_in = 1'b0;
    rdy_in = 1'b0;
    tick();
    check("midrst_valid", 32'(alu_valid), 32'd0);
    check("midrst_r1", alu_r1, 32'd0);
    check("midrst_rob", 32'(alu_rob_idx), 32'd0);
    check("midrst_op", 32'(alu_op_type), 32'd0);
    rst_in = 1'b1;
    rdy_in = 1'b1;
    tick();
    check("midrst_no_issue1", 32'(alu_valid), 32'd0);
    tick();
    check("midrst_no_issue2", 32'(alu_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
